// File: rtl/mm_result_requant.sv
// mm_result_requant
// Reads the matrix multiplier's result memory in row-major order once the
// multiplier signals completion. Each accumulator word gets its column bias
// added, is rounded and right-shifted, optionally passed through ReLU or
// LeakyReLU, saturated to DATA_W, and streamed out through a 2-entry FIFO.
module mm_result_requant #(
  parameter int M           = 4,
  parameter int N           = 3,
  parameter int DATA_W      = 8,
  parameter int SHIFT       = 4,
  parameter int LEAKY_SHIFT = 2,
  parameter int ADDR_W      = (M * N > 1) ? $clog2(M * N) : 1,
  parameter int COL_W       = (N > 1) ? $clog2(N) : 1,
  parameter int ROW_W       = (M > 1) ? $clog2(M) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  result_valid,
  output logic [ADDR_W-1:0]     matrix_raddr,
  input  logic [2*DATA_W-1:0]   matrix_in,
  input  logic [1:0]            act_mode,
  input  logic                  bias_en,
  input  logic [COL_W-1:0]      bias_addr,
  input  logic [2*DATA_W-1:0]   bias_in,
  output logic [DATA_W-1:0]     out_data,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_col,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int ACC_W = 2 * DATA_W;
  // Two guard bits: one for the bias add, one for the rounding constant.
  localparam int SUM_W = ACC_W + 2;
  localparam int NUM   = M * N;

  localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(NUM - 1);
  localparam logic [COL_W-1:0]        LAST_COL  = COL_W'(N - 1);
  localparam logic [COL_W:0]          NUM_COLS  = (COL_W + 1)'(N);
  localparam logic signed [SUM_W-1:0] ROUND_ADD = SUM_W'(2 ** (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] SAT_MAX   = SUM_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN   = SUM_W'(-(2 ** (DATA_W - 1)));
  localparam logic [DATA_W-1:0]       OUT_MAX   = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0]       OUT_MIN   = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  state_t              r_state;
  logic [1:0]          r_actMode;
  logic [ADDR_W-1:0]   r_raddr;
  logic [ROW_W-1:0]    r_issRow;
  logic [COL_W-1:0]    r_issCol;
  logic                r_inflight;
  logic                r_busy;
  logic                r_done;
  logic                r_overrun;

  logic [ACC_W-1:0]    r_bias [N];

  logic [DATA_W-1:0]   r_fifoData [2];
  logic [ROW_W-1:0]    r_fifoRow  [2];
  logic [COL_W-1:0]    r_fifoCol  [2];
  logic                r_fifoLast [2];
  logic                r_wrPtr;
  logic                r_rdPtr;
  logic [1:0]          r_fifoCount;

  logic                w_pop;
  logic                w_push;
  logic [1:0]          w_countNext;
  logic                w_credit;
  logic                w_start;
  logic                w_biasWrite;

  logic signed [SUM_W-1:0] w_accExt;
  logic signed [SUM_W-1:0] w_biasExt;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_round;
  logic signed [SUM_W-1:0] w_act;
  logic [DATA_W-1:0]       w_satData;

  // The data returned for the address issued last cycle is what gets pushed;
  // an address may only be issued if its data is guaranteed a FIFO slot.
  assign out_valid   = (r_fifoCount != 2'd0);
  assign w_pop       = out_valid && out_ready;
  assign w_push      = r_inflight;
  assign w_countNext = r_fifoCount + {1'b0, w_push} - {1'b0, w_pop};
  assign w_credit    = ({1'b0, r_fifoCount} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  // A start in the very cycle done is shown is treated as arriving while busy.
  assign w_start     = result_valid && !r_busy && !r_done;
  assign w_biasWrite = bias_en && (r_state == ST_IDLE) && !r_busy && ({1'b0, bias_addr} < NUM_COLS);

  assign matrix_raddr = r_raddr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign overrun      = r_overrun;
  assign out_data     = r_fifoData[r_rdPtr];
  assign out_row      = r_fifoRow[r_rdPtr];
  assign out_col      = r_fifoCol[r_rdPtr];
  assign out_last     = r_fifoLast[r_rdPtr];

  // Requantize the word on matrix_in: bias add, round-half-up shift, activation, saturate.
  always_comb begin
    w_accExt  = {{2{matrix_in[ACC_W-1]}}, matrix_in};
    w_biasExt = {{2{r_bias[r_issCol][ACC_W-1]}}, r_bias[r_issCol]};
    w_sum     = w_accExt + w_biasExt + ROUND_ADD;
    w_round   = w_sum >>> SHIFT;
    w_act     = w_round;
    if (w_round[SUM_W-1]) begin
      if (r_actMode == 2'd1) begin
        w_act = '0;
      end else if (r_actMode == 2'd2) begin
        w_act = w_round >>> LEAKY_SHIFT;
      end
    end
    if (w_act > SAT_MAX) begin
      w_satData = OUT_MAX;
    end else if (w_act < SAT_MIN) begin
      w_satData = OUT_MIN;
    end else begin
      w_satData = w_act[DATA_W-1:0];
    end
  end

  // Per-column bias storage, deliberately kept across resets.
  always_ff @(posedge clk) begin
    if (w_biasWrite) begin
      r_bias[bias_addr] <= bias_in;
    end
  end

  // Control FSM: start/overrun detection, address issue under FIFO credit, completion.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= ST_IDLE;
      r_actMode  <= '0;
      r_raddr    <= '0;
      r_issRow   <= '0;
      r_issCol   <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_overrun  <= result_valid && (r_busy || r_done);
      r_inflight <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_actMode  <= act_mode;
            r_busy     <= 1'b1;
            r_raddr    <= '0;
            r_issRow   <= '0;
            r_issCol   <= '0;
            r_inflight <= 1'b1;
            r_state    <= (NUM == 1) ? ST_DRAIN : ST_READ;
          end
        end
        ST_READ: begin
          if (w_credit) begin
            r_raddr    <= r_raddr + ADDR_W'(1);
            r_inflight <= 1'b1;
            if (r_issCol == LAST_COL) begin
              r_issCol <= '0;
              r_issRow <= r_issRow + ROW_W'(1);
            end else begin
              r_issCol <= r_issCol + COL_W'(1);
            end
            if ((r_raddr + ADDR_W'(1)) == LAST_ADDR) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_countNext == 2'd0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_raddr <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Two-entry output FIFO; the head entry drives the output port directly.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_fifoData[i] <= '0;
        r_fifoRow[i]  <= '0;
        r_fifoCol[i]  <= '0;
        r_fifoLast[i] <= 1'b0;
      end
      r_wrPtr     <= 1'b0;
      r_rdPtr     <= 1'b0;
      r_fifoCount <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifoData[r_wrPtr] <= w_satData;
        r_fifoRow[r_wrPtr]  <= r_issRow;
        r_fifoCol[r_wrPtr]  <= r_issCol;
        r_fifoLast[r_wrPtr] <= (r_raddr == LAST_ADDR);
        r_wrPtr             <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_fifoCount <= w_countNext;
    end
  end

endmodule

// File: tb/tb_mm_result_requant.sv
// tb_mm_result_requant
// Self-checking bench: a behavioural requantization model fills a scoreboard
// queue whenever a transfer is started, and a negedge monitor compares every
// handshake, stall and done/busy event against it.
`timescale 1ns/1ps
module tb_mm_result_requant;

  localparam int M           = 4;
  localparam int N           = 3;
  localparam int DATA_W      = 8;
  localparam int SHIFT       = 4;
  localparam int LEAKY_SHIFT = 2;
  localparam int ACC_W       = 2 * DATA_W;
  localparam int NUM         = M * N;
  localparam int ADDR_W      = 4;
  localparam int COL_W       = 2;
  localparam int ROW_W       = 2;

  typedef struct {
    int data;
    int row;
    int col;
    int last;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                result_valid = 1'b0;
  logic [ADDR_W-1:0]   matrix_raddr;
  logic [ACC_W-1:0]    matrix_in;
  logic [1:0]          act_mode = 2'd0;
  logic                bias_en = 1'b0;
  logic [COL_W-1:0]    bias_addr = '0;
  logic [ACC_W-1:0]    bias_in = '0;
  logic [DATA_W-1:0]   out_data;
  logic [ROW_W-1:0]    out_row;
  logic [COL_W-1:0]    out_col;
  logic                out_last;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic                busy;
  logic                done;
  logic                overrun;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  int   gotData[$];
  int   biasModel [N];
  logic [ACC_W-1:0] accMem [16];
  bit   checkEn = 1'b0;
  int   readyMode = 0;

  mm_result_requant #(
    .M(M), .N(N), .DATA_W(DATA_W), .SHIFT(SHIFT), .LEAKY_SHIFT(LEAKY_SHIFT),
    .ADDR_W(ADDR_W), .COL_W(COL_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .result_valid(result_valid),
    .matrix_raddr(matrix_raddr),
    .matrix_in(matrix_in),
    .act_mode(act_mode),
    .bias_en(bias_en),
    .bias_addr(bias_addr),
    .bias_in(bias_in),
    .out_data(out_data),
    .out_row(out_row),
    .out_col(out_col),
    .out_last(out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Result memory: data for an address is available within the same cycle.
  assign matrix_in = accMem[matrix_raddr];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int floorDiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  // Reference: plain integer arithmetic straight from the numeric rules.
  function automatic int requant(input int acc, input int bias, input int mode);
    int s, r;
    s = acc + bias;
    r = floorDiv(s + 2 ** (SHIFT - 1), 2 ** SHIFT);
    if (mode == 1 && r < 0) r = 0;
    if (mode == 2 && r < 0) r = floorDiv(r, 2 ** LEAKY_SHIFT);
    if (r > 2 ** (DATA_W - 1) - 1) r = 2 ** (DATA_W - 1) - 1;
    if (r < -(2 ** (DATA_W - 1))) r = -(2 ** (DATA_W - 1));
    return r;
  endfunction

  function automatic int accVal(input int i);
    logic signed [ACC_W-1:0] t;
    t = accMem[i];
    return int'(t);
  endfunction

  function automatic int gotAt(input int i);
    if (i < gotData.size()) return gotData[i];
    return 99999;
  endfunction

  task automatic writeBias(input int col, input int val, input bit expectTaken);
    logic signed [ACC_W-1:0] t;
    @(posedge clk); #1;
    t = ACC_W'(val);
    bias_en   = 1'b1;
    bias_addr = COL_W'(col);
    bias_in   = t;
    @(posedge clk); #1;
    bias_en = 1'b0;
    if (expectTaken && col < N) biasModel[col] = int'(t);
  endtask

  // Start a transfer and load the scoreboard with the model's expected stream.
  task automatic applyStimulus(input int mode, input bit checkLatency);
    exp_t e;
    @(posedge clk); #1;
    act_mode     = 2'(mode);
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
    act_mode     = 2'($urandom_range(0, 3));
    for (int i = 0; i < NUM; i++) begin
      e.data = requant(accVal(i), biasModel[i % N], mode);
      e.row  = i / N;
      e.col  = i % N;
      e.last = (i == NUM - 1) ? 1 : 0;
      expQ.push_back(e);
    end
    if (checkLatency) begin
      @(negedge clk);
      checkOutput("lat_valid_edge_k", int'(out_valid), 0);
      checkOutput("lat_raddr0", int'(matrix_raddr), 0);
      checkOutput("lat_busy", int'(busy), 1);
      @(negedge clk);
      checkOutput("lat_valid_edge_k1", int'(out_valid), 1);
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || busy || done) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) checkOutput({name, "_timeout"}, expQ.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic runOne(input int mode, input string name);
    gotData.delete();
    applyStimulus(mode, 1'b0);
    waitIdle(name);
  endtask

  // Output ready driver: held high, or random with occasional 10-cycle low stretches.
  initial begin
    int lowCnt;
    lowCnt = 0;
    forever begin
      @(posedge clk); #1;
      if (readyMode == 0) begin
        out_ready = 1'b1;
      end else if (lowCnt > 0) begin
        out_ready = 1'b0;
        lowCnt--;
      end else if ($urandom_range(0, 9) == 0) begin
        out_ready = 1'b0;
        lowCnt = 9;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Compare process: handshakes vs scoreboard, stall stability, done/busy timing.
  initial begin
    bit prevStall;
    bit doneExpect;
    logic [DATA_W-1:0] prevData;
    logic [ROW_W-1:0]  prevRow;
    logic [COL_W-1:0]  prevCol;
    logic              prevLast;
    exp_t e;
    prevStall  = 1'b0;
    doneExpect = 1'b0;
    prevData = '0; prevRow = '0; prevCol = '0; prevLast = 1'b0;
    forever begin
      @(negedge clk);
      if (!checkEn || rst_n) begin
        prevStall  = 1'b0;
        doneExpect = 1'b0;
        continue;
      end
      if (doneExpect) begin
        checkOutput("done_pulse", int'(done), 1);
        checkOutput("busy_fall", int'(busy), 0);
        doneExpect = 1'b0;
      end else if (done) begin
        checkOutput("done_spurious", int'(done), 0);
      end
      if (prevStall) begin
        checkOutput("stall_valid", int'(out_valid), 1);
        checkOutput("stall_data", int'(out_data), int'(prevData));
        checkOutput("stall_row", int'(out_row), int'(prevRow));
        checkOutput("stall_col", int'(out_col), int'(prevCol));
        checkOutput("stall_last", int'(out_last), int'(prevLast));
      end
      if (expQ.size() > 0) checkOutput("busy_high", int'(busy), 1);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_output", int'(out_valid), 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_data", int'($signed(out_data)), e.data);
          checkOutput("out_row", int'(out_row), e.row);
          checkOutput("out_col", int'(out_col), e.col);
          checkOutput("out_last", int'(out_last), e.last);
          gotData.push_back(int'($signed(out_data)));
          if (e.last != 0) doneExpect = 1'b1;
        end
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevRow   = out_row;
      prevCol   = out_col;
      prevLast  = out_last;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int mode;
    for (int i = 0; i < 16; i++) accMem[i] = '0;
    for (int c = 0; c < N; c++) biasModel[c] = 0;

    // Reset state.
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    checkOutput("rst_raddr", int'(matrix_raddr), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    rst_n   = 1'b0;
    checkEn = 1'b1;

    // Model pins.
    checkOutput("pin_model_bias", requant(100, 8, 0), 7);
    checkOutput("pin_model_leaky", requant(-40, 0, 2), -1);
    checkOutput("pin_model_satneg", requant(-3000, 0, 0), -128);

    // Bias add + rounding, first-output latency.
    writeBias(0, 8, 1'b1);
    writeBias(1, -5, 1'b1);
    writeBias(2, 20, 1'b1);
    accMem[0] = 16'd100;
    for (int i = 1; i < NUM; i++) accMem[i] = ACC_W'(int'($urandom_range(0, 4000)) - 2000);
    gotData.delete();
    applyStimulus(0, 1'b1);
    waitIdle("t1");
    checkOutput("t1_lit_7", gotAt(0), 7);

    // Activation modes on a negative value.
    writeBias(0, 0, 1'b1);
    accMem[0] = ACC_W'(-40);
    runOne(0, "t2m0");
    checkOutput("t2_mode0_lit", gotAt(0), -2);
    runOne(1, "t2m1");
    checkOutput("t2_mode1_lit", gotAt(0), 0);
    runOne(2, "t2m2");
    checkOutput("t2_mode2_lit", gotAt(0), -1);

    // Saturation at both rails; bias write to an out-of-range column is ignored.
    writeBias(1, 0, 1'b1);
    writeBias(3, 1234, 1'b1);
    accMem[0] = ACC_W'(3000);
    accMem[1] = ACC_W'(-3000);
    runOne(0, "t3");
    checkOutput("t3_sat_pos_lit", gotAt(0), 127);
    checkOutput("t3_sat_neg_lit", gotAt(1), -128);

    // Random matrices and biases, ready held high.
    for (int run = 0; run < 4; run++) begin
      for (int c = 0; c < N; c++)
        writeBias(c, (run < 2) ? int'($urandom_range(0, 65535)) - 32768
                               : int'($urandom_range(0, 800)) - 400, 1'b1);
      for (int i = 0; i < NUM; i++)
        accMem[i] = (run < 2) ? ACC_W'($urandom)
                              : ACC_W'(int'($urandom_range(0, 6000)) - 3000);
      mode = int'($urandom_range(0, 3));
      runOne(mode, "t4");
      checkOutput("t4_count", gotData.size(), NUM);
    end

    // Random backpressure, overrun mid-transfer, bias write while busy.
    readyMode = 1;
    for (int run = 0; run < 3; run++) begin
      for (int i = 0; i < NUM; i++) accMem[i] = ACC_W'(int'($urandom_range(0, 6000)) - 3000);
      gotData.delete();
      applyStimulus(int'($urandom_range(0, 2)), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      result_valid = 1'b1;
      @(posedge clk); #1;
      result_valid = 1'b0;
      checkOutput("overrun_pulse", int'(overrun), 1);
      @(posedge clk); #1;
      checkOutput("overrun_clear", int'(overrun), 0);
      writeBias(0, 777, 1'b0);
      waitIdle("t5");
      checkOutput("t5_count", gotData.size(), NUM);
    end
    readyMode = 0;

    // Reset after element 5: immediate clear, then restart from address 0 with retained bias.
    for (int i = 0; i < NUM; i++) accMem[i] = ACC_W'(int'($urandom_range(0, 6000)) - 3000);
    gotData.delete();
    applyStimulus(0, 1'b0);
    n = 0;
    while (gotData.size() < 6 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checkOutput("t6_reached_elem5", (gotData.size() >= 6) ? 1 : 0, 1);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("t6_rst_valid", int'(out_valid), 0);
    checkOutput("t6_rst_busy", int'(busy), 0);
    checkOutput("t6_rst_raddr", int'(matrix_raddr), 0);
    checkOutput("t6_rst_data", int'(out_data), 0);
    checkOutput("t6_rst_last", int'(out_last), 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    runOne(1, "t6");
    checkOutput("t6_restart_count", gotData.size(), NUM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_result_requant.md
Name: mm_result_requant

Overview:
- Downstream consumer of the matrix multiplier's result memory. On the multiplier's result_valid pulse it reads all M*N signed 2*DATA_W accumulator words in row-major order via a read-address port.
- For each word it adds a per-column bias, applies a rounding right shift and optional ReLU/LeakyReLU, and saturates to DATA_W.
- Results stream out on a valid/ready interface to the next layer's feature-map loader.

Parameters:
M, 4, result rows
N, 3, result columns
DATA_W, 8, output data width; accumulator width is 2*DATA_W
SHIFT, 4, requant right shift (>=1)
LEAKY_SHIFT, 2, LeakyReLU negative-slope shift (slope = 2^-LEAKY_SHIFT)
ADDR_W, $clog2(M*N), result address width
COL_W, $clog2(N) (min 1), column index width
ROW_W, $clog2(M) (min 1), row index width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
result_valid  in  1  one-cycle pulse from the multiplier: result memory complete
matrix_raddr  out  ADDR_W  result memory read address (registered)
matrix_in  in  2*DATA_W  signed read data, valid one clk after matrix_raddr changes
act_mode  in  2  0 none, 1 ReLU, 2 LeakyReLU, 3 treated as none; sampled on start
bias_en  in  1  bias write strobe
bias_addr  in  COL_W  bias column index
bias_in  in  2*DATA_W  signed bias value
out_data  out  DATA_W  signed requantized value
out_row  out  ROW_W  row of out_data
out_col  out  COL_W  column of out_data
out_last  out  1  high with final element (row M-1, col N-1)
out_valid  out  1  output handshake valid
out_ready  in  1  output handshake ready
busy  out  1  high from start to final handshake
done  out  1  one-cycle pulse after the final handshake
overrun  out  1  one-cycle pulse when result_valid arrives while busy

Behaviour:
- Reset (rst_n=1, async) clears: all outputs 0, FSM to IDLE, FIFO empty, address counter 0. Bias RAM is not cleared.
- FSM IDLE:
  - result_valid=1 latches act_mode, sets busy, and goes to READ.
  - bias_en writes bias[bias_addr]; bias_addr>=N is ignored. Writes are honoured only in IDLE; bias_en while busy is ignored.
- FSM READ:
  - Issues addresses 0..M*N-1 in order, at most one per clk.
  - Credit rule: an address is issued only if fifo_count + inflight - pop < 2. fifo_count is the occupancy of the 2-entry output FIFO; inflight is 1 if an address was issued in the previous clk; pop is out_valid&&out_ready this clk.
  - Moves to DRAIN once address M*N-1 has been issued.
- FSM DRAIN: waits for FIFO empty after the last handshake, pulses done, clears busy, resets matrix_raddr to 0, and returns to IDLE.
- Latency:
  - result_valid sampled at edge k, so address 0 is driven after edge k.
  - The data is sampled at edge k+1 and written to the FIFO, so out_valid is high after edge k+1.
  - Throughput is 1 element/clk with out_ready held high.
- Datapath, in this order:
  - s = acc + bias[col], computed at 2*DATA_W+1 bits with no wrap.
  - r = (s + 2^(SHIFT-1)) >>> SHIFT: arithmetic shift, round half toward +inf.
  - Activation: ReLU gives max(r,0). Leaky gives r>>>LEAKY_SHIFT if r<0 (floor), otherwise r.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Output interface:
  - out_row and out_col are those of the element's address.
  - out_data, out_row, out_col and out_last are stable while out_valid && !out_ready; out_valid never drops without a handshake.
- Boundaries:
  - result_valid while busy is ignored and pulses overrun; the current transfer is unaffected.
  - result_valid coincident with the done cycle counts as busy and pulses overrun.
  - out_ready low for any length fills the FIFO and stalls issue with no loss or duplication.
  - M*N=1: that single element has out_last=1.
  - Reset mid-transfer aborts immediately. The next result_valid restarts from address 0.

Test Plan:
- Bias[0]=8, acc[0]=100, mode 0, out_ready=1 -> out_data=7, row0 col0. First out_valid 2 edges after result_valid.
- acc=-40, bias=0: mode 0 -> -2; mode 1 -> 0; mode 2 -> -1.
- acc=3000 -> 127; acc=-3000 -> -128 (mode 0, bias 0).
- Full 4x3 result with a random 2*DATA_W-bit signed matrix and random bias, reference model checks all 12 outputs in row-major order. out_last only on element 11, done one clk after its handshake, busy falls with done.
- out_ready toggled randomly (including 10-clk low stretches) -> same 12 values, no duplicates or drops, outputs stable while stalled. Second result_valid mid-transfer -> overrun pulse, output stream unchanged.
- rst_n=1 pulse after element 5 -> all outputs 0 immediately. A new result_valid afterwards restarts at address 0, and bias values are retained.
